// File: rtl/conv_pkg.sv
// Shared types and helpers for the sliding-window generator: FSM states,
// index-width helper, stride normalisation and the window-count formula.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } conv_state_e;

    // Bits needed to index n entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A stride of zero behaves as stride one.
    function automatic logic [1:0] norm_stride(input logic [1:0] s);
        return (s == 2'd0) ? 2'd1 : s;
    endfunction

    // Advance a mod-stride phase counter.
    function automatic logic [1:0] phase_inc(input logic [1:0] p, input logic [1:0] s);
        logic [1:0] n;
        n = p + 2'd1;
        return (n >= s) ? 2'd0 : n;
    endfunction

    // Number of windows a w x h frame yields for kernel k and stride s.
    function automatic int unsigned windows_per_frame(input int unsigned w, input int unsigned h,
                                                      input int unsigned k, input int unsigned s);
        int unsigned sn;
        sn = (s == 0) ? 1 : s;
        if (w < k || h < k) return 0;
        return ((w - k) / sn + 1) * ((h - k) / sn + 1);
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One line of pixel history: a DEPTH x WIDTH RAM with one write port and one
// read port. The read is registered so it maps onto block RAM.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, read every cycle
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KSIZE x KSIZE window generator over a raster pixel stream with
// per-frame width/height/stride and valid/ready backpressure on the output.
// Optional macro CONV_WIN_COUNT_EN adds a per-frame accepted-window counter.
//
// The line buffers are read one cycle ahead: the read address is always the
// column the next pixel will land on, so on the accepting edge the previous
// rows of that column are already on the RAM outputs. That edge writes the
// pixel, forwards each buffer's old value to the next buffer, shifts the
// window and (when a window is due) loads win_data, all at once.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int KSIZE     = 3,
    parameter int MAX_W     = 64,
    parameter int MAX_H     = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [1:0]                       stride,
    input  logic [$clog2(MAX_W+1)-1:0]       img_w,
    input  logic [$clog2(MAX_H+1)-1:0]       img_h,
    input  logic                             pix_valid,
    input  logic [BIT_DEPTH-1:0]             pix_data,
    output logic                             pix_ready,
    output logic                             win_valid,
    input  logic                             win_ready,
    output logic [KSIZE*KSIZE*BIT_DEPTH-1:0] win_data,
    output logic                             shift_buffer,
    output logic                             busy,
    output logic                             done,
`ifdef CONV_WIN_COUNT_EN
    output logic [$clog2(MAX_W*MAX_H+1)-1:0] win_count,
`endif
    output logic                             err
);

    localparam int WW    = $clog2(MAX_W + 1);
    localparam int HW    = $clog2(MAX_H + 1);
    localparam int AW    = idx_width(MAX_W);
    localparam int NB    = KSIZE - 1;
    localparam int WIN_W = KSIZE * KSIZE * BIT_DEPTH;

    conv_state_e      state_q, state_d;
    logic [1:0]       stride_q;
    logic [WW-1:0]    w_q;
    logic [HW-1:0]    h_q;
    logic [WW-1:0]    col_q, col_d;
    logic [HW-1:0]    row_q, row_d;
    logic [1:0]       cph_q, cph_d;
    logic [1:0]       rph_q, rph_d;
    logic             win_valid_q, win_valid_d;
    logic [WIN_W-1:0] win_q, win_next;
    logic [WIN_W-1:0] win_data_q;
    logic             shift_q, shift_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             frame_start;
    logic             cfg_bad, pix_hs, emit, last_col, last_row;

    logic [BIT_DEPTH-1:0] col_in [KSIZE];
    logic [BIT_DEPTH-1:0] lb_rd  [NB];

    assign cfg_bad  = (img_w < WW'(KSIZE)) || (img_h < HW'(KSIZE)) ||
                      (img_w > WW'(MAX_W)) || (img_h > HW'(MAX_H));
    assign pix_ready = (state_q == ST_RUN) && (!win_valid_q || win_ready);
    assign pix_hs   = pix_valid && pix_ready;
    assign last_col = (col_q == (w_q - WW'(1)));
    assign last_row = (row_q == (h_q - HW'(1)));
    assign emit     = pix_hs && (col_q >= WW'(KSIZE - 1)) && (row_q >= HW'(KSIZE - 1)) &&
                      (cph_q == 2'd0) && (rph_q == 2'd0);

    // Next-state logic: frame FSM, raster counters and stride phases
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cph_d       = cph_q;
        rph_d       = rph_q;
        win_valid_d = win_valid_q;
        shift_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        frame_start = 1'b1;
                        col_d       = '0;
                        row_d       = '0;
                        cph_d       = 2'd0;
                        rph_d       = 2'd0;
                    end
                end
            end
            ST_RUN: begin
                if (pix_hs) begin
                    if (last_col) begin
                        col_d   = '0;
                        cph_d   = 2'd0;
                        row_d   = row_q + HW'(1);
                        rph_d   = (row_q == HW'(KSIZE - 2)) ? 2'd0 : phase_inc(rph_q, stride_q);
                        shift_d = 1'b1;
                        if (last_row) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_q + WW'(1);
                        cph_d = (col_q == WW'(KSIZE - 2)) ? 2'd0 : phase_inc(cph_q, stride_q);
                    end
                end
            end
            ST_DRAIN: begin
                if (!win_valid_q || win_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new window wins over a handshake of the old one on the same edge
        if (emit) begin
            win_valid_d = 1'b1;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // Control registers, frame config latch and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stride_q    <= 2'd0;
            w_q         <= '0;
            h_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cph_q       <= 2'd0;
            rph_q       <= 2'd0;
            win_valid_q <= 1'b0;
            shift_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cph_q       <= cph_d;
            rph_q       <= rph_d;
            win_valid_q <= win_valid_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            err_q       <= err_d;
            if (frame_start) begin
                stride_q <= norm_stride(stride);
                w_q      <= img_w;
                h_q      <= img_h;
            end
        end
    end

    // Line-buffer chain: buffer 0 takes the pixel, buffer i+1 takes buffer i's old value
    genvar gi, gj;
    assign col_in[KSIZE-1] = pix_data;
    for (gi = 0; gi < NB; gi++) begin : g_lb
        logic [BIT_DEPTH-1:0] wdata;
        if (gi == 0) begin : g_first
            assign wdata = pix_data;
        end else begin : g_chain
            assign wdata = lb_rd[gi-1];
        end
        conv_line_buf #(
            .DEPTH (MAX_W),
            .WIDTH (BIT_DEPTH),
            .AW    (AW)
        ) u_lb (
            .clk     (clk),
            .we_i    (pix_hs),
            .waddr_i (col_q[AW-1:0]),
            .wdata_i (wdata),
            .raddr_i (col_d[AW-1:0]),
            .rdata_o (lb_rd[gi])
        );
        // Oldest row sits at the top of the window
        assign col_in[NB-1-gi] = lb_rd[gi];
    end

    // Shifted window: each column moves left, the incoming column enters on the right
    for (gi = 0; gi < KSIZE; gi++) begin : g_row
        for (gj = 0; gj < KSIZE; gj++) begin : g_col
            if (gj < KSIZE - 1) begin : g_shift
                assign win_next[(gi*KSIZE+gj)*BIT_DEPTH +: BIT_DEPTH] =
                    win_q[(gi*KSIZE+gj+1)*BIT_DEPTH +: BIT_DEPTH];
            end else begin : g_load
                assign win_next[(gi*KSIZE+gj)*BIT_DEPTH +: BIT_DEPTH] = col_in[gi];
            end
        end
    end

    // Window shift register advances once per accepted pixel; output window loads on emit
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= '0;
            win_data_q <= '0;
        end else begin
            if (pix_hs) begin
                win_q <= win_next;
            end
            if (emit) begin
                win_data_q <= win_next;
            end
        end
    end

`ifdef CONV_WIN_COUNT_EN
    localparam int CNT_W = $clog2(MAX_W * MAX_H + 1);
    logic [CNT_W-1:0] win_count_q;

    // Accepted windows in the current frame; cleared when a frame starts
    always_ff @(posedge clk) begin
        if (rst) begin
            win_count_q <= '0;
        end else if (frame_start) begin
            win_count_q <= '0;
        end else if (win_valid_q && win_ready) begin
            win_count_q <= win_count_q + CNT_W'(1);
        end
    end

    assign win_count = win_count_q;
`endif

    assign win_valid    = win_valid_q;
    assign win_data     = win_data_q;
    assign shift_buffer = shift_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a frame-level reference model pushes
// expected windows, a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int BD    = 8;
    localparam int K     = 3;
    localparam int MW    = 64;
    localparam int MH    = 64;
    localparam int WIN_W = K * K * BD;

    logic             clk = 1'b0;
    logic             rst, start, pix_valid, win_ready;
    logic [1:0]       stride;
    logic [6:0]       img_w, img_h;
    logic [BD-1:0]    pix_data;
    logic             pix_ready, win_valid, shift_buffer, busy, done, err;
    logic [WIN_W-1:0] win_data;
`ifdef CONV_WIN_COUNT_EN
    logic [$clog2(MW*MH+1)-1:0] win_count;
`endif

    conv_window_gen #(.BIT_DEPTH(BD), .KSIZE(K), .MAX_W(MW), .MAX_H(MH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stride       (stride),
        .img_w        (img_w),
        .img_h        (img_h),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data),
        .shift_buffer (shift_buffer),
        .busy         (busy),
        .done         (done),
`ifdef CONV_WIN_COUNT_EN
        .win_count    (win_count),
`endif
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int got_cnt = 0, done_cnt = 0, shift_cnt = 0, err_cnt = 0;
    int ready_mode = 0;
    logic [WIN_W-1:0] exp_q[$];
    logic [WIN_W-1:0] got_log[$];
    logic [BD-1:0]    frame [MH][MW];
    logic             stall_prev = 1'b0;
    logic [WIN_W-1:0] stall_data;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Window of a sequential frame of width w whose top-left pixel value is base
    function automatic logic [WIN_W-1:0] mk_win(input int base, input int w);
        logic [WIN_W-1:0] v;
        v = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r*K+c)*BD +: BD] = BD'(base + r*w + c);
        return v;
    endfunction

    task automatic chk_win(input string name, input int idx, input logic [WIN_W-1:0] expv);
        checks++;
        if (idx >= got_log.size()) begin
            errors++;
            $display("FAIL %s: window %0d never received", name, idx);
        end else if (got_log[idx] !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got_log[idx], expv);
        end
    endtask

    // Reference model: every window position stepping by stride, raster order
    task automatic push_expected(input int w, input int h, input int s);
        int sn;
        logic [WIN_W-1:0] v;
        sn = (s == 0) ? 1 : s;
        for (int ty = 0; ty + K <= h; ty += sn)
            for (int tx = 0; tx + K <= w; tx += sn) begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        v[(r*K+c)*BD +: BD] = frame[ty+r][tx+c];
                exp_q.push_back(v);
            end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (shift_buffer) shift_cnt++;
            if (err) err_cnt++;
            if (win_valid && stall_prev) begin
                checks++;
                if (win_data !== stall_data) begin
                    errors++;
                    $display("FAIL stall_stable: got %h expected %h", win_data, stall_data);
                end
            end
            if (win_valid && !win_ready) begin
                checks++;
                if (pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL pix_ready_stall: got %b expected 0", pix_ready);
                end
                stall_prev = 1'b1;
                stall_data = win_data;
            end else begin
                stall_prev = 1'b0;
            end
            if (win_valid && win_ready) begin
                got_cnt++;
                got_log.push_back(win_data);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL window_unexpected: got %h expected none", win_data);
                end else begin
                    logic [WIN_W-1:0] e;
                    e = exp_q.pop_front();
                    if (win_data !== e) begin
                        errors++;
                        $display("FAIL window_data: got %h expected %h", win_data, e);
                    end
                end
            end
        end
    end

    // Consumer readiness pattern
    initial begin
        int rcyc;
        rcyc = 0;
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            case (ready_mode)
                0:       win_ready = 1'b1;
                1:       win_ready = (rcyc % 3 == 0);
                default: win_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    task automatic do_start(input int w, input int h, input int s);
        start = 1'b1;
        img_w = 7'(w);
        img_h = 7'(h);
        stride = 2'(s);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feed up to n pixels of the frame; optional idle gaps and a stray start mid-frame
    task automatic feed(input int w, input int n, input bit gaps, input bit dup, output int idx);
        int budget;
        bit acc, dup_done;
        idx = 0;
        budget = 0;
        dup_done = 0;
        while (idx < n && budget < 20000) begin
            if (dup && idx == 3 && !dup_done) begin
                start = 1'b1;
                img_w = 7'd2;
                dup_done = 1;
            end else begin
                start = 1'b0;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data = frame[idx / w][idx % w];
            end
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            budget++;
            if (acc) idx++;
        end
        start = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic fill_frame(input int w, input int h, input bit seq);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                frame[y][x] = seq ? BD'(y*w + x) : BD'($urandom);
    endtask

    task automatic run_frame(input int w, input int h, input int s, input int rmode,
                             input bit seq, input bit dup, input int exp_n, input string tag);
        int g0, d0, sh0, e0, n, budget;
        fill_frame(w, h, seq);
        push_expected(w, h, s);
        g0 = got_cnt; d0 = done_cnt; sh0 = shift_cnt; e0 = err_cnt;
        ready_mode = rmode;
        do_start(w, h, s);
        chk({tag, "_busy_start"}, busy, 1);
        feed(w, w*h, !seq, dup, n);
        chk({tag, "_pixels_accepted"}, n, w*h);
        budget = 0;
        while (done_cnt == d0 && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk({tag, "_busy_after_done"}, busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_shift_pulses"}, shift_cnt - sh0, h);
        chk({tag, "_err_pulses"}, err_cnt - e0, 0);
        chk({tag, "_windows"}, got_cnt - g0, exp_n);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
`ifdef CONV_WIN_COUNT_EN
        chk({tag, "_win_count"}, win_count, exp_n);
`endif
        exp_q.delete();
        ready_mode = 0;
    endtask

    int bad_w[4] = '{2, 5, 65, 5};
    int bad_h[4] = '{5, 2, 5, 65};

    initial begin
        int g0, d0, e0, n;
        rst = 1'b1; start = 1'b0; stride = 2'd0; img_w = '0; img_h = '0;
        pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_data_zero", (win_data == '0), 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_shift", shift_buffer, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 5x5, stride 1
        g0 = got_log.size();
        run_frame(5, 5, 1, 0, 1, 0, 9, "s1");
        chk_win("s1_first", g0, mk_win(0, 5));
        chk_win("s1_last", g0 + 8, mk_win(12, 5));

        // 5x5, stride 2
        g0 = got_log.size();
        run_frame(5, 5, 2, 0, 1, 0, 4, "s2");
        chk_win("s2_first", g0, mk_win(0, 5));
        chk_win("s2_second", g0 + 1, mk_win(2, 5));
        chk_win("s2_last", g0 + 3, mk_win(12, 5));

        // Backpressure 1-of-3, plus a start pulse while busy that must be ignored
        run_frame(5, 5, 1, 1, 1, 1, 9, "stall");

        // Bad configurations
        for (int i = 0; i < 4; i++) begin
            g0 = got_cnt; e0 = err_cnt;
            do_start(bad_w[i], bad_h[i], 1);
            chk("bad_err_pulse", err, 1);
            chk("bad_done_pulse", done, 1);
            chk("bad_busy", busy, 0);
            pix_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bad_err_one_cycle", err, 0);
            chk("bad_pix_ready", pix_ready, 0);
            pix_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("bad_err_count", err_cnt - e0, 1);
            chk("bad_no_windows", got_cnt - g0, 0);
        end

        // Reset mid-frame after 12 pixels
        fill_frame(5, 5, 1);
        d0 = done_cnt; g0 = got_cnt;
        do_start(5, 5, 1);
        feed(5, 12, 0, 0, n);
        chk("midrst_fed", n, 12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pix_ready", pix_ready, 0);
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_shift", shift_buffer, 0);
        chk("midrst_win_data_zero", (win_data == '0), 1);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_windows", got_cnt - g0, 0);
        g0 = got_log.size();
        run_frame(5, 5, 1, 0, 1, 0, 9, "after_rst");
        chk_win("after_rst_first", g0, mk_win(0, 5));

        // 8x6 at stride 3
        run_frame(8, 6, 3, 0, 0, 0, 4, "w8h6s3");

        // Randomised frames, random backpressure and input gaps
        for (int f = 0; f < 6; f++) begin
            int w, h, s;
            w = $urandom_range(3, 10);
            h = $urandom_range(3, 8);
            s = $urandom_range(0, 3);
            run_frame(w, h, s, 2, 0, 0, int'(windows_per_frame(w, h, K, s)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
